// File: rtl/sonic_ranging_scheduler.sv
// ---------------------------------------------------------------------------
// sonic_ranging_scheduler
//
// Purpose: drives the ultrasonic ranger. It fires periodic trigger pulses,
// times the returned echo, converts the echo width to distance units, flags
// measurements that never complete, and keeps a debounced `near` level for the
// game state controller.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active low (0 = reset)
//   enable      1 = keep ranging, 0 = stop once the current period ends
//   echo        raw sensor echo (asynchronous, synchronised here)
//   trig        sensor trigger pulse
//   distance    last valid distance in units
//   dist_valid  one-cycle pulse when distance updates
//   timeout     one-cycle pulse when a measurement is aborted
//   near        debounced proximity level
//   busy        high in every state except IDLE
//
// States:
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   S_IDLE      | stopped; waits for enable
//   S_TRIG      | trig high for TRIG_CYCLES cycles
//   S_WAIT_RISE | waiting for the echo to rise, guarded by the timeout
//   S_MEASURE   | echo high; accumulating the width in distance units
//   S_HOLDOFF   | waiting out the rest of the ranging period
//
// PERIOD_CYCLES must exceed TIMEOUT_CYCLES, which must exceed TRIG_CYCLES.
// ---------------------------------------------------------------------------
module sonic_ranging_scheduler #(
    parameter int unsigned TRIG_CYCLES    = 1000,
    parameter int unsigned PERIOD_CYCLES  = 6_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 3_000_000,
    parameter int unsigned UNIT_CYCLES    = 5830,
    parameter int unsigned NEAR_THRESH    = 50,
    parameter int unsigned NEAR_COUNT     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        echo,
    output logic        trig,
    output logic [19:0] distance,
    output logic        dist_valid,
    output logic        timeout,
    output logic        near,
    output logic        busy
);

    localparam int unsigned CNT_W    = $clog2(PERIOD_CYCLES + 1);
    localparam int unsigned SUB_W    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int unsigned STREAK_W = $clog2(NEAR_COUNT + 1);

    localparam logic [CNT_W-1:0]    TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]    PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [SUB_W-1:0]    SUB_LAST     = SUB_W'(UNIT_CYCLES - 1);
    localparam logic [STREAK_W-1:0] STREAK_FULL  = STREAK_W'(NEAR_COUNT);
    localparam logic [19:0]         NEAR_LIM     = 20'(NEAR_THRESH);
    localparam logic [19:0]         UNIT_MAX     = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [SUB_W-1:0]    sub;
    logic [19:0]         unit;
    logic [STREAK_W-1:0] streak;

    logic echo_meta;
    logic echo_s;
    logic echo_d;
    logic echo_rise;
    logic echo_fall;

    logic [19:0]         width_units;
    logic [STREAK_W-1:0] streak_bump;
    logic                reading_near;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_d    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_d    <= echo_s;
        end
    end

    assign echo_rise = echo_s & ~echo_d;
    assign echo_fall = ~echo_s & echo_d;

    // The falling-edge cycle is itself part of the echo width, so it is folded
    // in here; this makes the loaded value exactly floor(width / UNIT_CYCLES).
    assign width_units = (sub == SUB_LAST && unit != UNIT_MAX) ? unit + 20'd1 : unit;

    assign reading_near = (width_units < NEAR_LIM);
    assign streak_bump  = (streak == STREAK_FULL) ? streak : streak + STREAK_W'(1);

    // One counter serves as both the period counter and the elapsed counter:
    // both are cleared together and both run from the first TRIG cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sub        <= '0;
            unit       <= '0;
            streak     <= '0;
            trig       <= 1'b0;
            distance   <= '0;
            dist_valid <= 1'b0;
            timeout    <= 1'b0;
            near       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            timeout    <= 1'b0;

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (enable) begin
                        state <= S_TRIG;
                        trig  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                S_TRIG: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == TRIG_LAST) begin
                        state <= S_WAIT_RISE;
                        trig  <= 1'b0;
                    end
                end

                S_WAIT_RISE: begin
                    cnt <= cnt + CNT_W'(1);
                    // A rise seen on the last allowed cycle could never be
                    // measured, so the timeout takes it.
                    if (cnt == TIMEOUT_LAST) begin
                        timeout <= 1'b1;
                        streak  <= '0;
                        near    <= 1'b0;
                        state   <= S_HOLDOFF;
                    end else if (echo_rise) begin
                        sub   <= '0;
                        unit  <= '0;
                        state <= S_MEASURE;
                    end
                end

                S_MEASURE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (echo_fall) begin
                        distance   <= width_units;
                        dist_valid <= 1'b1;
                        if (reading_near) begin
                            streak <= streak_bump;
                            near   <= (streak_bump == STREAK_FULL);
                        end else begin
                            streak <= '0;
                            near   <= 1'b0;
                        end
                        state <= S_HOLDOFF;
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout <= 1'b1;
                        streak  <= '0;
                        near    <= 1'b0;
                        state   <= S_HOLDOFF;
                    end else if (sub == SUB_LAST) begin
                        sub <= '0;
                        if (unit != UNIT_MAX) begin
                            unit <= unit + 20'd1;
                        end
                    end else begin
                        sub <= sub + SUB_W'(1);
                    end
                end

                S_HOLDOFF: begin
                    if (cnt == PERIOD_LAST) begin
                        cnt <= '0;
                        if (enable) begin
                            state <= S_TRIG;
                            trig  <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    trig  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sonic_ranging_scheduler.md
# sonic_ranging_scheduler

Sequences the ultrasonic ranger used by the game state controller. Issues periodic trigger pulses and times the returned echo. Converts echo width to a distance, flags missing echoes, and produces a debounced `near` level for the PLAY→WIN decision. It sits between the board `echo`/`trig` pins and the top-level state machine, and replaces free-running ranging with an enable-gated, timeout-protected measurement schedule.

## Interface
- `TRIG_CYCLES`, 1000: trig high width in clk cycles (10 µs at 100 MHz).
- `PERIOD_CYCLES`, 6_000_000: trig-start to next trig-start spacing (60 ms).
- `TIMEOUT_CYCLES`, 3_000_000: max cycles from trig start to echo fall before abort (30 ms).
- `UNIT_CYCLES`, 5830: echo-high cycles per distance unit (1 cm round trip at 100 MHz).
- `NEAR_THRESH`, 50: distance strictly below this counts as near.
- `NEAR_COUNT`, 3: consecutive near readings required to raise `near`.
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `enable`  input  1  level; 1 = keep ranging, 0 = stop after the current cycle.
- `echo`  input  1  asynchronous sensor echo; synchronised internally.
- `trig`  output  1  sensor trigger pulse.
- `distance`  output  20  last valid distance in units, unsigned.
- `dist_valid`  output  1  one-cycle pulse when `distance` updates.
- `timeout`  output  1  one-cycle pulse when a measurement is aborted.
- `near`  output  1  debounced proximity level.
- `busy`  output  1  high in every state except IDLE.

## Operation
- `echo` passes through a 2-FF synchroniser to give `echo_s`. Edges are detected on `echo_s` against its previous value.
- States: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: if `enable`=1, go to TRIG and clear the period counter and the elapsed counter.
- TRIG: `trig`=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE.
- WAIT_RISE: on a rising edge of `echo_s`, go to MEASURE and clear the width counters. If the elapsed count reaches TIMEOUT_CYCLES, pulse `timeout` and go to HOLDOFF. An echo already high on entry is not a rising edge; a stuck-high echo therefore times out.
- MEASURE: a sub-counter counts 0..UNIT_CYCLES-1. On each wrap, the unit counter increments, saturating at 2^20-1.
  - On a falling edge of `echo_s`: load `distance` with the unit counter (floor of width/UNIT_CYCLES), pulse `dist_valid`, go to HOLDOFF.
  - If the elapsed count reaches TIMEOUT_CYCLES: pulse `timeout`, leave `distance` unchanged, go to HOLDOFF.
  - A falling edge and timeout in the same cycle: the falling edge wins.
- HOLDOFF: when the period counter reaches PERIOD_CYCLES-1, go to TRIG if `enable`=1, otherwise to IDLE.
- The period counter and the elapsed counter both run from the first TRIG cycle.
- Dropping `enable` never truncates a trig pulse or a measurement. It only prevents the next cycle from starting.
- Near debounce:
  - A valid reading below NEAR_THRESH increments the streak counter, saturating at NEAR_COUNT. When the streak reaches NEAR_COUNT, `near` is set.
  - A valid reading at or above NEAR_THRESH, or any timeout, clears the streak and `near`.
- Reset (`rst`=0, any time, including mid-measurement): state IDLE; all counters 0; `trig`=0, `distance`=0, `dist_valid`=0, `timeout`=0, `near`=0, `busy`=0.

## Timing
- `enable` sampled 1 in IDLE → `trig` rises on the next clock edge.
- Trig starts are exactly PERIOD_CYCLES apart while `enable` stays 1, provided PERIOD_CYCLES > TIMEOUT_CYCLES (parameter constraint).
- Echo-to-state latency is 2 cycles for the synchroniser plus 1 cycle for edge detection.
- `dist_valid`, the `distance` update and any `near` change occur in the same cycle: the cycle after the falling edge is detected.
- `timeout` asserts in the cycle the elapsed count equals TIMEOUT_CYCLES.
- All outputs are registered.

## Test plan
Benches use TRIG_CYCLES=4, PERIOD_CYCLES=300, TIMEOUT_CYCLES=200, UNIT_CYCLES=10, NEAR_THRESH=5, NEAR_COUNT=3.
- Basic ranging: reset, `enable`=1, `echo` high for 73 cycles starting 20 cycles after trig rise → trig high for 4 cycles; one `dist_valid` pulse with `distance`=7; next trig 300 cycles after the first.
- No echo: `echo` held 0 → `timeout` pulse 200 cycles after trig start; `distance` keeps its previous value; `near`=0.
- Debounce: three consecutive readings of 3 → `near` rises with the third `dist_valid`; a following reading of 6 → `near` falls in that `dist_valid` cycle.
- Enable drop: `enable`=0 mid-MEASURE → the current reading still completes with `dist_valid`; no further trig; `busy` falls at the period boundary.
- Reset mid-MEASURE: assert `rst`=0 → all outputs 0 immediately; after release with `enable`=1, trig restarts one cycle later.
- Stuck echo: `echo`=1 before and through trig → no `dist_valid`; `timeout` after 200 cycles.
